// File: rtl/axilite_wr_arbiter.sv
// Two-requester AXI-Lite write arbiter: round-robin grant of one AW+W+B
// transaction at a time onto a shared downstream write port.
module axilite_wr_arbiter #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    // requester 0
    input  logic [ADDR_W-1:0]     s0_awaddr,
    input  logic                  s0_awvalid,
    output logic                  s0_awready,
    input  logic [DATA_W-1:0]     s0_wdata,
    input  logic [DATA_W/8-1:0]   s0_wstrb,
    input  logic                  s0_wvalid,
    output logic                  s0_wready,
    output logic [1:0]            s0_bresp,
    output logic                  s0_bvalid,
    input  logic                  s0_bready,
    // requester 1
    input  logic [ADDR_W-1:0]     s1_awaddr,
    input  logic                  s1_awvalid,
    output logic                  s1_awready,
    input  logic [DATA_W-1:0]     s1_wdata,
    input  logic [DATA_W/8-1:0]   s1_wstrb,
    input  logic                  s1_wvalid,
    output logic                  s1_wready,
    output logic [1:0]            s1_bresp,
    output logic                  s1_bvalid,
    input  logic                  s1_bready,
    // shared downstream port
    output logic [ADDR_W-1:0]     m_awaddr,
    output logic                  m_awvalid,
    input  logic                  m_awready,
    output logic [DATA_W-1:0]     m_wdata,
    output logic [DATA_W/8-1:0]   m_wstrb,
    output logic                  m_wvalid,
    input  logic                  m_wready,
    input  logic [1:0]            m_bresp,
    input  logic                  m_bvalid,
    output logic                  m_bready
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t r_state;
    logic   r_gnt;
    logic   r_rr;
    logic   r_aw_done;
    logic   r_w_done;

    logic   w_in_xfer;
    logic   w_in_resp;
    logic   w_sel_awvalid;
    logic   w_sel_wvalid;
    logic   w_sel_bready;
    logic   w_awready;
    logic   w_wready;
    logic   w_bvalid;
    logic   w_aw_hs;
    logic   w_w_hs;
    logic   w_aw_all;
    logic   w_w_all;
    logic   w_any_req;
    logic   w_pick;

    // Under contention the pointer decides; otherwise the lone requester wins.
    function automatic logic f_pick(input logic req0, input logic req1, input logic rr);
        logic pick;
        if (req0 && req1) begin
            pick = rr;
        end else begin
            pick = req1;
        end
        return pick;
    endfunction

    // Decode state and select the granted requester's control inputs.
    always_comb begin
        w_in_xfer     = (r_state == ST_XFER);
        w_in_resp     = (r_state == ST_RESP);
        w_sel_awvalid = r_gnt ? s1_awvalid : s0_awvalid;
        w_sel_wvalid  = r_gnt ? s1_wvalid  : s0_wvalid;
        w_sel_bready  = r_gnt ? s1_bready  : s0_bready;
        w_any_req     = s0_awvalid | s1_awvalid;
        w_pick        = f_pick(s0_awvalid, s1_awvalid, r_rr);
    end

    // Downstream request side: payload always follows the grant, valids only in XFER.
    always_comb begin
        m_awaddr  = r_gnt ? s1_awaddr : s0_awaddr;
        m_wdata   = r_gnt ? s1_wdata  : s0_wdata;
        m_wstrb   = r_gnt ? s1_wstrb  : s0_wstrb;
        m_awvalid = w_in_xfer & w_sel_awvalid & ~r_aw_done;
        m_wvalid  = w_in_xfer & w_sel_wvalid  & ~r_w_done;
        m_bready  = w_in_resp & w_sel_bready;
    end

    // Handshake bookkeeping; a channel already accepted stays closed until RESP.
    always_comb begin
        w_awready = w_in_xfer & m_awready & ~r_aw_done;
        w_wready  = w_in_xfer & m_wready  & ~r_w_done;
        w_bvalid  = w_in_resp & m_bvalid;
        w_aw_hs   = m_awvalid & m_awready;
        w_w_hs    = m_wvalid  & m_wready;
        w_aw_all  = r_aw_done | w_aw_hs;
        w_w_all   = r_w_done  | w_w_hs;
    end

    // Route ready/valid and response back to the granted requester only.
    always_comb begin
        s0_awready = 1'b0;
        s0_wready  = 1'b0;
        s0_bvalid  = 1'b0;
        s0_bresp   = 2'b00;
        s1_awready = 1'b0;
        s1_wready  = 1'b0;
        s1_bvalid  = 1'b0;
        s1_bresp   = 2'b00;
        if (r_gnt) begin
            s1_awready = w_awready;
            s1_wready  = w_wready;
            s1_bvalid  = w_bvalid;
            s1_bresp   = w_in_resp ? m_bresp : 2'b00;
        end else begin
            s0_awready = w_awready;
            s0_wready  = w_wready;
            s0_bvalid  = w_bvalid;
            s0_bresp   = w_in_resp ? m_bresp : 2'b00;
        end
    end

    // Transaction FSM with grant, round-robin pointer and per-channel done flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_gnt     <= 1'b0;
            r_rr      <= 1'b0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_aw_done <= 1'b0;
                    r_w_done  <= 1'b0;
                    if (w_any_req) begin
                        r_gnt   <= w_pick;
                        r_rr    <= ~w_pick;
                        r_state <= ST_XFER;
                    end else begin
                        r_gnt   <= r_gnt;
                        r_rr    <= r_rr;
                        r_state <= ST_IDLE;
                    end
                end
                ST_XFER: begin
                    if (w_aw_all && w_w_all) begin
                        r_aw_done <= 1'b0;
                        r_w_done  <= 1'b0;
                        r_state   <= ST_RESP;
                    end else begin
                        r_aw_done <= w_aw_all;
                        r_w_done  <= w_w_all;
                        r_state   <= ST_XFER;
                    end
                end
                ST_RESP: begin
                    r_aw_done <= 1'b0;
                    r_w_done  <= 1'b0;
                    if (m_bvalid && m_bready) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_state <= ST_RESP;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_aw_done <= 1'b0;
                    r_w_done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axilite_wr_arbiter.sv
// Directed bench for axilite_wr_arbiter; expected downstream beats and
// requester responses are queued at issue time and checked by a monitor.
module tb_axilite_wr_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] s0_awaddr, s1_awaddr, m_awaddr;
    logic        s0_awvalid, s0_awready, s1_awvalid, s1_awready;
    logic [63:0] s0_wdata, s1_wdata, m_wdata;
    logic [7:0]  s0_wstrb, s1_wstrb, m_wstrb;
    logic        s0_wvalid, s0_wready, s1_wvalid, s1_wready;
    logic [1:0]  s0_bresp, s1_bresp, m_bresp;
    logic        s0_bvalid, s0_bready, s1_bvalid, s1_bready;
    logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;

    always #5 clk = ~clk;

    axilite_wr_arbiter #(.ADDR_W(64), .DATA_W(64)) dut (
        .clk(clk), .rst_n(rst_n),
        .s0_awaddr(s0_awaddr), .s0_awvalid(s0_awvalid), .s0_awready(s0_awready),
        .s0_wdata(s0_wdata), .s0_wstrb(s0_wstrb), .s0_wvalid(s0_wvalid), .s0_wready(s0_wready),
        .s0_bresp(s0_bresp), .s0_bvalid(s0_bvalid), .s0_bready(s0_bready),
        .s1_awaddr(s1_awaddr), .s1_awvalid(s1_awvalid), .s1_awready(s1_awready),
        .s1_wdata(s1_wdata), .s1_wstrb(s1_wstrb), .s1_wvalid(s1_wvalid), .s1_wready(s1_wready),
        .s1_bresp(s1_bresp), .s1_bvalid(s1_bvalid), .s1_bready(s1_bready),
        .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready)
    );

    logic [8:0] outs;
    assign outs = {s0_awready, s0_wready, s0_bvalid, s1_awready, s1_wready, s1_bvalid,
                   m_awvalid, m_wvalid, m_bready};

    int n_chk = 0;
    int n_pass = 0;
    logic [63:0] q_aw[$];
    logic [71:0] q_w[$];
    logic [2:0]  q_b[$];
    logic got_maw, got_mw, s0_seen, mv_seen, mbr_seen, s0_bv_low;

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Scoreboard monitor: every accepted beat or response must match the queue head.
    always @(negedge clk) begin
        if (rst_n) begin
            if (m_awvalid && m_awready) begin
                if (q_aw.size() == 0) chk("aw_unexpected", 72'(q_aw.size()), 72'd1);
                else chk("m_awaddr", 72'(m_awaddr), 72'(q_aw.pop_front()));
            end
            if (m_wvalid && m_wready) begin
                if (q_w.size() == 0) chk("w_unexpected", 72'(q_w.size()), 72'd1);
                else chk("m_wstrb_wdata", {m_wstrb, m_wdata}, q_w.pop_front());
            end
            if (s0_bvalid && s0_bready) begin
                if (q_b.size() == 0) chk("b0_unexpected", 72'(q_b.size()), 72'd1);
                else chk("s0_b_id_resp", 72'({1'b0, s0_bresp}), 72'(q_b.pop_front()));
            end
            if (s1_bvalid && s1_bready) begin
                if (q_b.size() == 0) chk("b1_unexpected", 72'(q_b.size()), 72'd1);
                else chk("s1_b_id_resp", 72'({1'b1, s1_bresp}), 72'(q_b.pop_front()));
            end
        end
    end

    // One cycle: sample at negedge, then retire handshaken valids after posedge.
    task automatic step();
        logic a0, w0, a1, w1, mb;
        @(negedge clk);
        a0 = s0_awvalid & s0_awready;
        w0 = s0_wvalid & s0_wready;
        a1 = s1_awvalid & s1_awready;
        w1 = s1_wvalid & s1_wready;
        mb = m_bvalid & m_bready;
        if (m_awvalid && m_awready) got_maw = 1'b1;
        if (m_wvalid && m_wready) got_mw = 1'b1;
        s0_seen   = s0_seen | s0_awready | s0_wready | s0_bvalid;
        mv_seen   = mv_seen | m_awvalid | m_wvalid;
        mbr_seen  = mbr_seen | m_bready;
        s0_bv_low = s0_bv_low | ~s0_bvalid;
        @(posedge clk);
        #1;
        if (a0) s0_awvalid = 1'b0;
        if (w0) s0_wvalid = 1'b0;
        if (a1) s1_awvalid = 1'b0;
        if (w1) s1_wvalid = 1'b0;
        if (mb) m_bvalid = 1'b0;
    endtask

    task automatic issue(input logic id, input logic [63:0] a, input logic [63:0] d,
                         input logic [1:0] br, input logic aw_en);
        logic [7:0] st;
        st = id ? 8'h0F : 8'hF0;
        q_aw.push_back(a);
        q_w.push_back({st, d});
        q_b.push_back({id, br});
        if (id) begin
            s1_awaddr = a; s1_wdata = d; s1_wstrb = st;
            s1_awvalid = aw_en; s1_wvalid = 1'b1;
        end else begin
            s0_awaddr = a; s0_wdata = d; s0_wstrb = st;
            s0_awvalid = aw_en; s0_wvalid = 1'b1;
        end
    endtask

    task automatic run_xfer(input logic [1:0] br);
        got_maw = 1'b0;
        got_mw  = 1'b0;
        for (int k = 0; k < 20 && !(got_maw && got_mw); k++) step();
        chk("aw_w_handshakes", 72'({got_maw, got_mw}), 72'b11);
        m_bresp  = br;
        m_bvalid = 1'b1;
        for (int k = 0; k < 20 && m_bvalid; k++) step();
        chk("b_handshake", 72'(m_bvalid), 72'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        s0_awaddr = 64'd0; s0_awvalid = 1'b0; s0_wdata = 64'd0; s0_wstrb = 8'd0;
        s0_wvalid = 1'b0; s0_bready = 1'b0;
        s1_awaddr = 64'd0; s1_awvalid = 1'b0; s1_wdata = 64'd0; s1_wstrb = 8'd0;
        s1_wvalid = 1'b0; s1_bready = 1'b0;
        m_awready = 1'b0; m_wready = 1'b0; m_bresp = 2'b00; m_bvalid = 1'b0;
        got_maw = 1'b0; got_mw = 1'b0; s0_seen = 1'b0; mv_seen = 1'b0;
        mbr_seen = 1'b0; s0_bv_low = 1'b0;

        @(negedge clk);
        chk("reset_outs", 72'(outs), 72'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // single requester s1, s0 must stay quiet
        m_awready = 1'b1; m_wready = 1'b1; s1_bready = 1'b1; s0_seen = 1'b0;
        issue(1'b1, 64'h100, 64'hA5, 2'b00, 1'b1);
        run_xfer(2'b00);
        chk("s0_quiet", 72'(s0_seen), 72'd0);

        // contention twice: s0 first each time
        s0_bready = 1'b1;
        issue(1'b0, 64'h200, 64'h11, 2'b01, 1'b1);
        issue(1'b1, 64'h300, 64'h22, 2'b00, 1'b1);
        run_xfer(2'b01);
        run_xfer(2'b00);
        issue(1'b0, 64'h400, 64'h33, 2'b00, 1'b1);
        issue(1'b1, 64'h500, 64'h44, 2'b01, 1'b1);
        run_xfer(2'b00);
        run_xfer(2'b01);

        // W three cycles ahead of AW; W held off after AW to keep XFER open
        mv_seen = 1'b0; s0_seen = 1'b0;
        issue(1'b0, 64'h600, 64'h66, 2'b00, 1'b0);
        for (int k = 0; k < 3; k++) step();
        chk("pre_aw_quiet", 72'({mv_seen, s0_seen}), 72'd0);
        m_wready = 1'b0; got_maw = 1'b0; got_mw = 1'b0;
        s0_awvalid = 1'b1;
        for (int k = 0; k < 10 && !got_maw; k++) step();
        chk("aw_only_hs", 72'({got_maw, got_mw}), 72'b10);
        m_bresp = 2'b00; m_bvalid = 1'b1; mbr_seen = 1'b0; s0_seen = 1'b0;
        step(); step();
        chk("no_resp_before_w", 72'({mbr_seen, s0_seen}), 72'd0);
        m_wready = 1'b1;
        for (int k = 0; k < 10 && m_bvalid; k++) step();
        chk("w_late_done", 72'({got_mw, m_bvalid}), 72'b10);

        // B backpressure from s0
        s0_bready = 1'b0; got_maw = 1'b0; got_mw = 1'b0;
        issue(1'b0, 64'h700, 64'h77, 2'b00, 1'b1);
        for (int k = 0; k < 10 && !(got_maw && got_mw); k++) step();
        chk("bp_req_done", 72'({got_maw, got_mw}), 72'b11);
        m_bvalid = 1'b1; mbr_seen = 1'b0; s0_bv_low = 1'b0;
        for (int k = 0; k < 4; k++) step();
        chk("bp_hold", 72'({mbr_seen, s0_bv_low}), 72'd0);
        s0_bready = 1'b1;
        step();
        chk("bp_release", 72'(m_bvalid), 72'd0);
        m_bvalid = 1'b1;
        @(negedge clk);
        chk("bp_idle", 72'({s0_bvalid, m_bready}), 72'd0);
        @(posedge clk); #1;
        m_bvalid = 1'b0;

        // SLVERR pass-through to s1
        issue(1'b1, 64'h800, 64'h88, 2'b10, 1'b1);
        run_xfer(2'b10);

        // reset in the middle of an s0 transaction
        m_awready = 1'b0; m_wready = 1'b0;
        s0_awaddr = 64'h900; s0_wdata = 64'h99; s0_awvalid = 1'b1; s0_wvalid = 1'b1;
        step(); step();
        chk("xfer_before_rst", 72'({m_awvalid, m_wvalid}), 72'b11);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_outs", 72'(outs), 72'd0);
        s0_awvalid = 1'b0; s0_wvalid = 1'b0;
        m_awready = 1'b1; m_wready = 1'b1;
        step(); step();
        rst_n = 1'b1;
        issue(1'b0, 64'hA00, 64'hAA, 2'b00, 1'b1);
        issue(1'b1, 64'hB00, 64'hBB, 2'b01, 1'b1);
        run_xfer(2'b00);
        run_xfer(2'b01);
        step();

        chk("queues_drained", 72'({q_aw.size() == 0, q_w.size() == 0, q_b.size() == 0}), 72'b111);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/axilite_wr_arbiter.md
AXILITE_WR_ARBITER -- requirements
Module: axilite_wr_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 64, giving the AXI-Lite address width.
REQ-002 The block SHALL have parameter DATA_W, default 64, giving the AXI-Lite write-data width; strobe width is DATA_W/8.
REQ-003 The block SHALL use one clock and an asynchronous active-low reset.
REQ-004 Port clk, input, 1: sole clock; all state updates on the rising edge.
REQ-005 Port rst_n, input, 1: asynchronous active-low reset.
REQ-006 Ports sN_awaddr (N=0,1), input, ADDR_W: requester N write address.
REQ-007 Ports sN_awvalid, input, 1 / sN_awready, output, 1: requester N AW handshake.
REQ-008 Ports sN_wdata, input, DATA_W / sN_wstrb, input, DATA_W/8: requester N write data and strobes.
REQ-009 Ports sN_wvalid, input, 1 / sN_wready, output, 1: requester N W handshake.
REQ-010 Ports sN_bresp, output, 2 / sN_bvalid, output, 1 / sN_bready, input, 1: requester N B channel.
REQ-011 Ports m_awaddr, output, ADDR_W / m_awvalid, output, 1 / m_awready, input, 1: shared downstream AW channel toward the NoC bridge.
REQ-012 Ports m_wdata, output, DATA_W / m_wstrb, output, DATA_W/8 / m_wvalid, output, 1 / m_wready, input, 1: shared downstream W channel.
REQ-013 Ports m_bresp, input, 2 / m_bvalid, input, 1 / m_bready, output, 1: shared downstream B channel.

Function
REQ-014 The block SHALL implement an FSM with states IDLE, XFER and RESP, plus a 1-bit register gnt (selected requester), a 1-bit register rr (priority pointer), and flags aw_done and w_done.
REQ-015 In IDLE, a request from requester N SHALL be sN_awvalid=1; sN_wvalid alone SHALL NOT request.
REQ-016 In IDLE with exactly one request, gnt SHALL load that requester and the state SHALL go to XFER on the next edge.
REQ-017 In IDLE with both requests, gnt SHALL load rr.
REQ-018 On every IDLE->XFER transition, rr SHALL load ~(new gnt).
REQ-019 In XFER, m_awvalid SHALL be sgnt_awvalid & ~aw_done, and m_aw* payload SHALL mirror sgnt; sgnt_awready SHALL be m_awready & ~aw_done.
REQ-020 In XFER, m_wvalid SHALL be sgnt_wvalid & ~w_done, and m_w* payload SHALL mirror sgnt; sgnt_wready SHALL be m_wready & ~w_done.
REQ-021 AW and W handshakes SHALL be accepted in either order or in the same cycle; each SHALL set its done flag.
REQ-022 When both handshakes have completed, including when both complete in the same cycle, the state SHALL go to RESP on the next edge and both flags SHALL clear.
REQ-023 In RESP, sgnt_bvalid SHALL be m_bvalid, sgnt_bresp SHALL be m_bresp, and m_bready SHALL be sgnt_bready.
REQ-024 On the m_bvalid & m_bready handshake in RESP, the state SHALL go to IDLE; a new grant SHALL be possible on the following cycle, giving one idle cycle between transactions.
REQ-025 The non-granted requester, and both requesters in IDLE, SHALL see awready=0, wready=0 and bvalid=0.
REQ-026 Outside XFER, m_awvalid and m_wvalid SHALL be 0; outside RESP, m_bready SHALL be 0.
REQ-027 Payload outputs SHALL be combinational muxes on gnt; the valid/ready paths SHALL have zero added latency inside XFER and RESP.
REQ-028 At most one transaction SHALL be outstanding downstream at any time.
REQ-029 The block SHALL NOT alter bresp values, including SLVERR (2'b10), which SHALL pass through unchanged.

Reset
REQ-030 When rst_n=0, the block SHALL asynchronously force state=IDLE, gnt=0, rr=0 and aw_done=w_done=0.
REQ-031 During reset, all ready/valid outputs SHALL be 0.
REQ-032 Reset asserted mid-transaction SHALL abandon that transaction with no response returned to the requester.
REQ-033 After rst_n deasserts, the first contended grant SHALL go to requester 0.

Verification
REQ-034 The bench SHALL cover the single-requester case: s1 writes addr 0x100, data 0xA5, with m_awready=m_wready=1 and B returned OKAY -> m_awaddr=0x100, s1_bresp=0, s0 sees no ready or valid.
REQ-035 The bench SHALL cover contention after reset: s0 and s1 assert awvalid in the same cycle -> s0 is served first, then s1, then s0 is served first again on the next contention.
REQ-036 The bench SHALL cover W before AW: wvalid is presented 3 cycles before awvalid -> no m_awvalid until awvalid is present; RESP is entered only after both handshakes complete.
REQ-037 The bench SHALL cover backpressure: m_bvalid is held 4 cycles with s0_bready=0 -> m_bready=0 and the state stays RESP; it returns to IDLE on the cycle s0_bready=1.
REQ-038 The bench SHALL cover SLVERR pass-through: m_bresp=2'b10 -> granted requester receives bresp=2'b10.
REQ-039 The bench SHALL cover mid-transaction reset: rst_n pulsed low during XFER -> all valid/ready outputs are 0 immediately, and the first contended grant after release goes to s0.
